// File: rtl/mux_nx1_pkg.sv
// mux_nx1_pkg: shared defaults, channel-index width helper and output-stage state encoding
package mux_nx1_pkg;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_CHANNELS = 4;
  localparam int DEF_DEPTH    = 4;
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  typedef enum logic {ST_EMPTY = 1'b0, ST_LOADED = 1'b1} out_state_e;
endpackage

// File: rtl/mux_chan_fifo.sv
// mux_chan_fifo: per-channel FIFO with combinational head; caller guarantees no push when full, no pop when empty
module mux_chan_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, rp_q;
  logic [AW:0]      cnt_q;
  always_ff @(posedge clk) if (push) mem_q[wp_q] <= wdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  assign rdata = mem_q[rp_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNTW'(DEPTH));
endmodule

// File: rtl/mux_nx1_rr.sv
// mux_nx1_rr: N-to-1 buffered mux, per-channel FIFOs drained into one stallable output register.
// MUX_NX1_STRICT_PRIORITY_EN selects fixed priority instead of round-robin arbitration.
module mux_nx1_rr
  import mux_nx1_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int DEPTH    = DEF_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CHANNELS*WIDTH-1:0]     in_data,
  input  logic [CHANNELS-1:0]           in_valid,
  output logic [CHANNELS-1:0]           in_full,
  output logic [CHANNELS-1:0]           err_overflow,
  output logic [WIDTH-1:0]              out_data,
  output logic [chan_w(CHANNELS)-1:0]   out_channel,
  output logic                          out_valid,
  input  logic                          out_ready
);
  localparam int CW = chan_w(CHANNELS);
  logic [CHANNELS-1:0] empty, full, push, pop;
  logic [WIDTH-1:0]    rdata [CHANNELS];
  logic [CW-1:0]       win;
  logic                load;
  out_state_e          state_q, state_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [CW-1:0]       chan_q, chan_d;
  logic [CHANNELS-1:0] ovf_q;
  // in_full comes from the count register, so a same-cycle pop never admits a push
  assign push = in_valid & ~full;
  assign load = (state_q == ST_EMPTY || out_ready) && !(&empty);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    mux_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[c]),
      .wdata (in_data[c*WIDTH +: WIDTH]),
      .pop   (pop[c]),
      .rdata (rdata[c]),
      .empty (empty[c]),
      .full  (full[c])
    );
    assign pop[c] = load && (win == CW'(c));
  end
`ifdef MUX_NX1_STRICT_PRIORITY_EN
  always_comb begin
    win = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) if (!empty[i]) win = CW'(i);
  end
`else
  logic [CW-1:0] last_q;
  // scan from farthest to nearest so the nearest non-empty channel after last_q wins
  always_comb begin
    win = '0;
    for (int i = CHANNELS; i >= 1; i--)
      if (!empty[(int'(last_q) + i) % CHANNELS]) win = CW'((int'(last_q) + i) % CHANNELS);
  end
  always_ff @(posedge clk) begin
    if (reset) last_q <= CW'(CHANNELS - 1);
    else if (load) last_q <= win;
  end
`endif
  always_comb begin
    state_d = load ? ST_LOADED : (state_q == ST_LOADED && out_ready) ? ST_EMPTY : state_q;
    data_d  = load ? rdata[win] : data_q;
    chan_d  = load ? win : chan_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      chan_q  <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      ovf_q   <= ovf_q | (in_valid & full);
    end
  end
  assign in_full      = full;
  assign err_overflow = ovf_q;
  assign out_data     = data_q;
  assign out_channel  = chan_q;
  assign out_valid    = (state_q == ST_LOADED);
endmodule

// File: tb/tb_mux_nx1_rr.sv
// tb_mux_nx1_rr: directed and random stimulus checked against a queue-based reference model
module tb_mux_nx1_rr;
  localparam int W = 8, CH = 4, DEPTH = 4;
  logic              clk = 1'b0, reset = 1'b1, out_ready = 1'b0, out_valid;
  logic [CH*W-1:0]   in_data = '0;
  logic [CH-1:0]     in_valid = '0, in_full, err_overflow;
  logic [W-1:0]      out_data;
  logic [1:0]        out_channel;
  int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;
  logic [W-1:0] mq [CH][$];
  logic         m_ov;
  logic [W-1:0] m_od;
  int           m_och, m_last;
  logic [CH-1:0] m_err;
  int rr_exp [8];

  mux_nx1_rr #(.WIDTH(W), .CHANNELS(CH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_full(in_full),
    .err_overflow(err_overflow), .out_data(out_data), .out_channel(out_channel),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [CH-1:0] v, input logic [CH*W-1:0] d, input logic rdy, input logic rst);
    logic [CH-1:0] fullnow;
    int win;
    if (rst) begin
      for (int c = 0; c < CH; c++) mq[c].delete();
      m_ov = 0; m_od = '0; m_och = 0; m_err = '0; m_last = CH - 1;
    end else begin
      for (int c = 0; c < CH; c++) fullnow[c] = (mq[c].size() == DEPTH);
      win = -1;
      if (!m_ov || rdy) begin
`ifdef MUX_NX1_STRICT_PRIORITY_EN
        for (int i = 0; i < CH; i++) if (win < 0 && mq[i].size() > 0) win = i;
`else
        for (int i = 1; i <= CH; i++) begin
          int k = (m_last + i) % CH;
          if (win < 0 && mq[k].size() > 0) win = k;
        end
`endif
        if (win >= 0) begin
          m_od = mq[win].pop_front(); m_och = win; m_ov = 1; m_last = win;
        end else m_ov = 0;
      end
      for (int c = 0; c < CH; c++)
        if (v[c]) begin
          if (fullnow[c]) m_err[c] = 1'b1;
          else mq[c].push_back(d[c*W +: W]);
        end
    end
  endtask

  task automatic compare_all(input logic rst);
    logic [CH-1:0] ef;
    for (int c = 0; c < CH; c++) ef[c] = (mq[c].size() == DEPTH);
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov || rst) begin
      chk("out_data", 32'(out_data), 32'(m_od));
      chk("out_channel", 32'(out_channel), 32'(m_och));
    end
    chk("in_full", 32'(in_full), 32'(ef));
    chk("err_overflow", 32'(err_overflow), 32'(m_err));
  endtask

  task automatic step(input logic [CH-1:0] v, input logic [CH*W-1:0] d, input logic rdy, input logic rst);
    @(negedge clk);
    in_valid = v; in_data = d; out_ready = rdy; reset = rst;
    @(posedge clk);
    model_edge(v, d, rdy, rst);
    #1;
    compare_all(rst);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step('0, '0, 1'b1, 1'b0);
  endtask

  initial begin
`ifdef MUX_NX1_STRICT_PRIORITY_EN
    rr_exp = '{0, 0, 1, 1, 2, 2, 3, 3};
`else
    rr_exp = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    step(4'hF, 32'hDEADBEEF, 1'b1, 1'b1);
    step(4'hF, 32'h12345678, 1'b1, 1'b1);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    step(4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00}, 1'b1, 1'b0);
    chk("lat_k", 32'(out_valid), 32'h0);
    step('0, '0, 1'b1, 1'b0);
    chk("lat_k1_valid", 32'(out_valid), 32'h1);
    chk("lat_k1_data", 32'(out_data), 32'hA5);
    chk("lat_k1_chan", 32'(out_channel), 32'h2);
    step('0, '0, 1'b1, 1'b0);
    chk("lat_k2_valid", 32'(out_valid), 32'h0);
    step('0, '0, 1'b1, 1'b1);
    step(4'hF, {8'h40, 8'h30, 8'h20, 8'h10}, 1'b0, 1'b0);
    step(4'hF, {8'h40, 8'h30, 8'h20, 8'h10}, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("rr_seq", 32'(out_channel), 32'(rr_exp[i]));
      step('0, '0, 1'b1, 1'b0);
    end
    step(4'b0001, 32'h55, 1'b0, 1'b0);
    step(4'b0001, 32'h66, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step((i < 2) ? 4'b0001 : 4'b0000, 32'(8'h77 + 8'(i * 17)), 1'b0, 1'b0);
      chk("bp_hold", 32'(out_data), 32'h55);
    end
    drain(5);
    for (int i = 1; i <= 6; i++) step(4'b0010, 32'(i) << 8, 1'b0, 1'b0);
    chk("ovf_full1", 32'(in_full[1]), 32'h1);
    chk("ovf_err1", 32'(err_overflow[1]), 32'h1);
    drain(6);
    for (int i = 0; i < 5; i++) step(4'b0001, 32'(8'hC0 + 8'(i)), 1'b0, 1'b0);
    chk("pf_full0", 32'(in_full[0]), 32'h1);
    step(4'b0001, 32'h77, 1'b1, 1'b0);
    chk("pf_err0", 32'(err_overflow[0]), 32'h1);
    chk("pf_notfull0", 32'(in_full[0]), 32'h0);
    drain(6);
    for (int i = 0; i < 400; i++)
      step(CH'($urandom), $urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
